// File: rtl/dmem_bus_responder_if.sv
// CPU data-memory request/response bus: one request per valid/ready handshake,
// answered by a single-cycle resp_valid pulse carrying load data or an error flag.
// Modports: master = CPU side (drives requests), slave = responder side.
interface dmem_bus_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_half;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_byte, req_half, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_half, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_bus_responder.sv
// Data-memory responder: translates CPU virtual addresses (minus BASE_ADDR) onto a
// word-wide single-port sync RAM; sub-word stores use read-modify-write.
// Latency after handshake: error 1, word store 2, load 3, sub-word store 4
// (2 with DMEM_WSTRB_EN). One transaction outstanding; req_ready only in IDLE.
// Ports: clk_i, rst_ni (async active-low), bus (slave modport), ram_* RAM port.
// Optional macro DMEM_WSTRB_EN adds ram_wstrb_o and byte-strobed sub-word stores.
module dmem_bus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          ADDR_W    = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dmem_bus_responder_if.slave   bus,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [31:0]           ram_wdata_o,
`ifdef DMEM_WSTRB_EN
    output logic [3:0]            ram_wstrb_o,
`endif
    input  logic [31:0]           ram_rdata_i
);
    localparam int OFF_W = ADDR_W + 2;

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

    state_t state_q, state_d;

    logic             write_q, byte_q, half_q, signed_q, err_q;
    logic [OFF_W-1:0] off_q;
    logic [31:0]      word_q;   // store data, later the merged word for RMW
    logic [31:0]      rdata_q;
`ifdef DMEM_WSTRB_EN
    logic [3:0]       strb_q;
`endif

    // Request decode (only meaningful in the handshake cycle)
    logic [31:0] offset;
    logic        is_half, is_word, req_err, hs;

    assign offset  = bus.req_addr - BASE_ADDR;
    // byte wins over half; neither set means a word access
    assign is_half = bus.req_half & ~bus.req_byte;
    assign is_word = ~bus.req_half & ~bus.req_byte;
    assign req_err = (|offset[31:OFF_W])
                   | (is_half & bus.req_addr[0])
                   | (is_word & (|bus.req_addr[1:0]));
    assign hs      = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (req_err)              state_d = RESP;
                    else if (!bus.req_write)  state_d = READ;
                    else if (is_word)         state_d = WRITE;
                    else
`ifdef DMEM_WSTRB_EN
                                              state_d = WRITE;
`else
                                              state_d = READ;
`endif
                end
            end
            READ:    state_d = MERGE;
            MERGE:   state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for RMW stores
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext, merged;

    always_comb begin
        lane_b   = ram_rdata_i[{off_q[1:0], 3'b000} +: 8];
        lane_h   = ram_rdata_i[{off_q[1], 4'b0000} +: 16];
        load_ext = ram_rdata_i;
        if (byte_q)      load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
        else if (half_q) load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
        merged = ram_rdata_i;
        if (byte_q)      merged[{off_q[1:0], 3'b000} +: 8]  = word_q[7:0];
        else if (half_q) merged[{off_q[1], 4'b0000} +: 16]  = word_q[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            half_q   <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            off_q    <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
`ifdef DMEM_WSTRB_EN
            strb_q   <= '0;
`endif
        end else begin
            if (hs) begin
                write_q  <= bus.req_write;
                byte_q   <= bus.req_byte;
                half_q   <= is_half;
                signed_q <= bus.req_signed;
                err_q    <= req_err;
                off_q    <= offset[OFF_W-1:0];
`ifdef DMEM_WSTRB_EN
                // replicate sub-word data so the strobe alone picks the lane
                if (bus.req_byte)  word_q <= {4{bus.req_wdata[7:0]}};
                else if (is_half)  word_q <= {2{bus.req_wdata[15:0]}};
                else               word_q <= bus.req_wdata;
                if (bus.req_byte)  strb_q <= 4'b0001 << offset[1:0];
                else if (is_half)  strb_q <= offset[1] ? 4'b1100 : 4'b0011;
                else               strb_q <= 4'b1111;
`else
                word_q   <= bus.req_wdata;
`endif
            end
            if (state_q == MERGE) begin
                if (write_q) word_q  <= merged;
                else         rdata_q <= load_ext;
            end
        end
    end

    // RAM port: address/data are held registers so they read 0 out of reset
    assign ram_en_o    = (state_q == READ) || (state_q == WRITE);
    assign ram_we_o    = (state_q == WRITE);
    assign ram_addr_o  = off_q[OFF_W-1:2];
    assign ram_wdata_o = word_q;
`ifdef DMEM_WSTRB_EN
    assign ram_wstrb_o = (state_q == WRITE) ? strb_q : 4'b0000;
`endif

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) & err_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: table of directed requests against a RAM model,
// plus hand sequences for reset state, back-to-back handshakes and reset mid-store.
// Works with or without DMEM_WSTRB_EN defined.
module tb_dmem_bus_responder;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ram_en, ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
`ifdef DMEM_WSTRB_EN
    logic [3:0]  ram_wstrb;
    localparam int SUB_LAT = 2;
    localparam int SUB_EN  = 1;
`else
    localparam int SUB_LAT = 4;
    localparam int SUB_EN  = 2;
`endif

    dmem_bus_responder_if bus();

    dmem_bus_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
`ifdef DMEM_WSTRB_EN
        .ram_wstrb_o (ram_wstrb),
`endif
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous single-port RAM model
    logic [31:0] mem [32];
    int          en_cnt = 0;
    logic [3:0]  last_strb = '0;
    always @(posedge clk_i) begin
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
`ifdef DMEM_WSTRB_EN
                last_strb <= ram_wstrb;
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
`else
                mem[ram_addr] <= ram_wdata;
`endif
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr, byt, half, sgn;
        logic [31:0] addr, wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        chk_mem;
        int          mem_idx;
        logic [31:0] exp_mem;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t vecs [17];

    task automatic run_vec(input vec_t v, input int id);
        int lat;
        int en0;
        int exp_en;
        @(negedge clk_i);
        chk($sformatf("v%0d_ready", id), {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_byte   = v.byt;
        bus.req_half   = v.half;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(posedge clk_i);
        #1;
        en0 = en_cnt;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
        chk($sformatf("v%0d_err", id), {31'b0, bus.resp_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_rdata", id), bus.resp_rdata, v.exp_rdata);
        if (v.exp_err) exp_en = 0;
        else if (v.wr && (v.byt || v.half)) exp_en = SUB_EN;
        else exp_en = 1;
        chk($sformatf("v%0d_ram_en_cycles", id), en_cnt - en0, exp_en);
        if (v.chk_mem) chk($sformatf("v%0d_mem", id), mem[v.mem_idx], v.exp_mem);
`ifdef DMEM_WSTRB_EN
        if (v.wr && !v.exp_err) chk($sformatf("v%0d_wstrb", id), {28'b0, last_strb}, {28'b0, v.exp_strb});
`endif
        @(posedge clk_i);
        #1;
        chk($sformatf("v%0d_pulse_end", id), {31'b0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        bit ok;
        // wr byt half sgn addr wdata err lat rdata chk idx mem strb
        vecs[0]  = '{1,0,0,0, 32'h1001_0004, 32'hDEAD_BEEF, 0, 2,       32'h0000_0000, 1, 1,  32'hDEAD_BEEF, 4'b1111};
        vecs[1]  = '{1,1,0,0, 32'h1001_0005, 32'hFFFF_FF12, 0, SUB_LAT, 32'h0000_0000, 1, 1,  32'hDEAD_12EF, 4'b0010};
        vecs[2]  = '{0,1,0,1, 32'h1001_0007, 32'h0,         0, 3,       32'hFFFF_FFDE, 0, 0,  32'h0,         4'b0000};
        vecs[3]  = '{0,0,0,0, 32'h1001_0004, 32'h0,         0, 3,       32'hDEAD_12EF, 0, 0,  32'h0,         4'b0000};
        vecs[4]  = '{1,0,1,0, 32'h1001_0006, 32'h1234_ABCD, 0, SUB_LAT, 32'hDEAD_12EF, 1, 1,  32'hABCD_12EF, 4'b1100};
        vecs[5]  = '{0,0,0,0, 32'h1001_0004, 32'h0,         0, 3,       32'hABCD_12EF, 0, 0,  32'h0,         4'b0000};
        vecs[6]  = '{1,0,0,0, 32'h1001_0004, 32'h8001_0000, 0, 2,       32'hABCD_12EF, 1, 1,  32'h8001_0000, 4'b1111};
        vecs[7]  = '{0,0,1,1, 32'h1001_0006, 32'h0,         0, 3,       32'hFFFF_8001, 0, 0,  32'h0,         4'b0000};
        vecs[8]  = '{0,0,1,0, 32'h1001_0006, 32'h0,         0, 3,       32'h0000_8001, 0, 0,  32'h0,         4'b0000};
        vecs[9]  = '{0,0,0,0, 32'h1001_0002, 32'h0,         1, 1,       32'h0000_8001, 0, 0,  32'h0,         4'b0000};
        vecs[10] = '{0,0,0,0, 32'h1001_0080, 32'h0,         1, 1,       32'h0000_8001, 0, 0,  32'h0,         4'b0000};
        vecs[11] = '{0,0,0,0, 32'h1000_FFFC, 32'h0,         1, 1,       32'h0000_8001, 0, 0,  32'h0,         4'b0000};
        vecs[12] = '{1,0,1,0, 32'h1001_0003, 32'hFFFF_FFFF, 1, 1,       32'h0000_8001, 1, 0,  32'h0000_0000, 4'b0000};
        vecs[13] = '{1,1,0,0, 32'h1001_007F, 32'h0000_005A, 0, SUB_LAT, 32'h0000_8001, 1, 31, 32'h5A00_0000, 4'b1000};
        vecs[14] = '{0,1,1,0, 32'h1001_007F, 32'h0,         0, 3,       32'h0000_005A, 0, 0,  32'h0,         4'b0000};
        vecs[15] = '{0,0,1,1, 32'h1001_007E, 32'h0,         0, 3,       32'h0000_5A00, 0, 0,  32'h0,         4'b0000};
        vecs[16] = '{0,0,1,0, 32'h1001_0004, 32'h0,         0, 3,       32'h0000_0000, 0, 0,  32'h0,         4'b0000};

        for (int i = 0; i < 32; i++) mem[i] = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
        bus.req_half = 1'b0; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state
        #2;
        chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
        chk("rst_ram_en",     {31'b0, ram_en},         32'd0);
        chk("rst_ram_we",     {31'b0, ram_we},         32'd0);
        chk("rst_ram_addr",   {27'b0, ram_addr},       32'd0);
        chk("rst_ram_wdata",  ram_wdata,               32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Back-to-back: load then word store with req_valid held high
        @(negedge clk_i);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_byte = 1'b0;
        bus.req_half = 1'b0; bus.req_signed = 1'b0; bus.req_addr = 32'h1001_0004;
        @(posedge clk_i);
        #1;
        bus.req_write = 1'b1; bus.req_addr = 32'h1001_0008; bus.req_wdata = 32'h55AA_55AA;
        ok = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin
                @(posedge clk_i);
                #1;
            end
            if (bus.req_ready !== 1'b0) ok = 1'b0;
        end
        chk("b2b_busy_ready_low", {31'b0, ok}, 32'd1);
        chk("b2b_load_resp",      {31'b0, bus.resp_valid}, 32'd1);
        chk("b2b_load_rdata",     bus.resp_rdata, 32'h8001_0000);
        @(posedge clk_i);
        #1;
        chk("b2b_idle_ready",     {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk_i);
        #1;
        bus.req_valid = 1'b0;
        chk("b2b_second_hs",      {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk_i);
        #1;
        chk("b2b_store_resp",     {31'b0, bus.resp_valid}, 32'd1);
        chk("b2b_store_mem",      mem[2], 32'h55AA_55AA);
        @(posedge clk_i);

        // Reset asserted in WRITE of a byte store
        @(negedge clk_i);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_byte = 1'b1;
        bus.req_half = 1'b0; bus.req_addr = 32'h1001_0008; bus.req_wdata = 32'h0000_0077;
        @(posedge clk_i);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 8 && ram_we !== 1'b1; c++) begin
            @(posedge clk_i);
            #1;
        end
        chk("mid_reached_write", {31'b0, ram_we}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_we_drop",    {31'b0, ram_we}, 32'd0);
        chk("mid_en_drop",    {31'b0, ram_en}, 32'd0);
        chk("mid_no_resp",    {31'b0, bus.resp_valid}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("mid_mem_intact", mem[2], 32'h55AA_55AA);
        rst_ni = 1'b1;
        #1;
        chk("mid_ready",      {31'b0, bus.req_ready}, 32'd1);
        chk("mid_rdata_zero", bus.resp_rdata, 32'd0);
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            if (bus.resp_valid !== 1'b0) ok = 1'b0;
        end
        chk("mid_no_late_resp", {31'b0, ok}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_bus_responder.md
Name: dmem_bus_responder

Overview:
- Responder side of the CPU data-memory request interface.
- Accepts one load or store per valid/ready handshake and translates the virtual address by subtracting BASE_ADDR.
- Drives a word-wide, single-port synchronous RAM. Sub-word stores use read-modify-write.
- Returns a one-cycle response pulse carrying load data (sign/zero-extended) or an error flag. Replaces the combinational DMEM path when the multi-cycle CPU runs with a stall-capable memory stage.

Parameters:
- BASE_ADDR, 32'h1001_0000, virtual address of RAM word 0.
- ADDR_W, 5, RAM word-address width. Depth is 2**ADDR_W words, i.e. 128 bytes by default.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  byte access.
- req_half  in  1  halfword access. req_byte has priority over req_half; neither set = word.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  32  virtual byte address.
- req_wdata  in  32  store data; low byte/half used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result.
- resp_err  out  1  qualifies resp_valid: misaligned or out-of-range access.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; ram_en=0; ram_we=0; ram_addr=0; ram_wdata=0.
- Reset mid-operation: the transaction is abandoned, no RAM write completes after reset assertion, and no response is issued.
- req_ready is 1 only in IDLE. On handshake (req_valid & req_ready) all request fields are latched, offset = req_addr - BASE_ADDR (32-bit wrap), and the FSM leaves IDLE.
- Error check at handshake:
  - Error if offset >= 4*2**ADDR_W (unsigned).
  - Error if a half access has addr[0]=1.
  - Error if a word access has addr[1:0]!=0.
  - Erroring requests go to RESP with no RAM access.
- States: IDLE, READ, MERGE, WRITE, RESP.
- Load path: IDLE -> READ (ram_en=1, ram_we=0, ram_addr=offset[ADDR_W+1:2]) -> MERGE (capture ram_rdata, extract lane, extend) -> RESP.
- Word store: IDLE -> WRITE (ram_en=1, ram_we=1, ram_wdata=req_wdata) -> RESP.
- Sub-word store: IDLE -> READ -> MERGE (replace the addressed lane in the captured word) -> WRITE with the merged word -> RESP.
- Lanes are little-endian. Byte lane = offset[1:0]; half lane = offset[1] (low or high 16 bits).
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_err=1 only for an error; otherwise resp_err=0.
  - resp_rdata is updated only on a successful load and holds its value otherwise.
- Latency, counted in cycles after the handshake edge; the response is in the Nth cycle:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Back-to-back requests: a new handshake is possible in the cycle after RESP. No pipelining; at most one transaction is outstanding.
- ram_en and ram_we are deasserted in every state other than those listed.

Optional Feature:
- Macro DMEM_WSTRB_EN.
- When defined: an extra port ram_wstrb (out, 4) is added. Sub-word stores skip READ/MERGE and go IDLE -> WRITE -> RESP, for a latency of 2. The store data is replicated across lanes and ram_wstrb selects the lane(s): 4'b1111 for word stores, 0 when not writing.
- When undefined: no ram_wstrb port, and read-modify-write is used as described above.

Test Plan:
- Reset, then a word store of 0xDEADBEEF to 0x1001_0004 -> WRITE with ram_addr=1; resp_valid in cycle 2, resp_err=0.
- Byte store of 0x12 to 0x1001_0005 over RAM word 0xDEADBEEF -> READ then WRITE of 0xDEAD12EF; resp in cycle 4 (cycle 2 with DMEM_WSTRB_EN, ram_wstrb=4'b0010).
- Signed half load at 0x1001_0006 from word 0x8001_0000 -> resp_rdata=0xFFFF8001. The unsigned load returns 0x00008001. Both respond in cycle 3.
- Word load from 0x1001_0002 -> resp_err=1 in cycle 1, no ram_en; the same happens for 0x1001_0080 and 0x1000_FFFC.
- Back-to-back load then store with req_valid held high -> req_ready=0 between handshakes; the second handshake lands in the cycle after the first RESP.
- rst asserted during the WRITE state of a sub-word store -> ram_we drops immediately, no resp_valid; after release req_ready=1 and resp_rdata=0.
